// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and round-robin pointer helper for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_WAIT  = 3'd2,
        RD_RELAY = 3'd3,
        WR_RELAY = 3'd4
    } arb_state_t;

    // Modulo increment of a round-robin pointer: n-1 wraps to 0.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating priority find (first request at or after start)
module rr_priority_pick #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] shifted;

    // Rotating a doubled copy puts req[start] at bit 0, req[start+1] at bit 1, ...
    assign doubled = {req, req};
    assign shifted = doubled >> start;

    // Lowest set bit of the rotated view wins; map its offset back to a requester index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (shifted[k]) begin
                found = 1'b1;
                idx   = IDW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one memory channel; optional MEM_ARB_TIMEOUT_EN watchdog
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CONSUMERS-1:0]         consumer_read_valid,
    input  logic [ADDR_BITS-1:0]             consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]         consumer_read_ready,
    output logic [DATA_BITS-1:0]             consumer_read_data [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0]         consumer_write_valid,
    input  logic [ADDR_BITS-1:0]             consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]             consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]         consumer_write_ready,
    output logic                             mem_read_valid,
    output logic [ADDR_BITS-1:0]             mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [DATA_BITS-1:0]             mem_read_data,
    output logic                             mem_write_valid,
    output logic [ADDR_BITS-1:0]             mem_write_address,
    output logic [DATA_BITS-1:0]             mem_write_data,
    input  logic                             mem_write_ready,
    output logic                             busy,
    output logic [$clog2(NUM_CONSUMERS)-1:0] grant_id
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                             err_timeout,
    output logic [$clog2(NUM_CONSUMERS)-1:0] err_id
`endif
);

    localparam int IDW = $clog2(NUM_CONSUMERS);

    arb_state_t             state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]         grant_q, grant_d;
    logic                   mrv_q, mrv_d;
    logic                   mwv_q, mwv_d;
    logic [ADDR_BITS-1:0]   mra_q, mra_d;
    logic [ADDR_BITS-1:0]   mwa_q, mwa_d;
    logic [DATA_BITS-1:0]   mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0] crr_q, crr_d;
    logic [NUM_CONSUMERS-1:0] cwr_q, cwr_d;
    logic [DATA_BITS-1:0]   crd_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   crd_d [NUM_CONSUMERS];

    logic [NUM_CONSUMERS-1:0] wr_req;
    logic [NUM_CONSUMERS-1:0] any_req;
    logic                     pick_found;
    logic [IDW-1:0]           pick_idx;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

    logic [WD_BITS-1:0] wd_q, wd_d;
    logic               et_q, et_d;
    logic [IDW-1:0]     eid_q, eid_d;
`endif

    // With writes disabled, write requests are invisible to arbitration.
    assign wr_req  = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign any_req = consumer_read_valid | wr_req;

    rr_priority_pick #(
        .N   (NUM_CONSUMERS),
        .IDW (IDW)
    ) u_pick (
        .req   (any_req),
        .start (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic for the grant / wait / relay sequence.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        mrv_d    = mrv_q;
        mwv_d    = mwv_q;
        mra_d    = mra_q;
        mwa_d    = mwa_q;
        mwd_d    = mwd_q;
        crr_d    = crr_q;
        cwr_d    = cwr_q;
        crd_d    = crd_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wd_d     = wd_q;
        et_d     = et_q;
        eid_d    = eid_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = IDW'(rr_next(32'(pick_idx), 32'(NUM_CONSUMERS)));
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_d     = '0;
`endif
                    // A winner holding both request types is served read first.
                    if (consumer_read_valid[pick_idx]) begin
                        mrv_d   = 1'b1;
                        mra_d   = consumer_read_address[pick_idx];
                        state_d = RD_WAIT;
                    end else begin
                        mwv_d   = 1'b1;
                        mwa_d   = consumer_write_address[pick_idx];
                        mwd_d   = consumer_write_data[pick_idx];
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_read_ready) begin
                    mrv_d          = 1'b0;
                    crr_d[grant_q] = 1'b1;
                    crd_d[grant_q] = mem_read_data;
                    state_d        = RD_RELAY;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    mrv_d          = 1'b0;
                    crr_d[grant_q] = 1'b1;
                    crd_d[grant_q] = '0;
                    et_d           = 1'b1;
                    eid_d          = grant_q;
                    state_d        = RD_RELAY;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            WR_WAIT: begin
                if (mem_write_ready) begin
                    mwv_d          = 1'b0;
                    cwr_d[grant_q] = 1'b1;
                    state_d        = WR_RELAY;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    mwv_d          = 1'b0;
                    cwr_d[grant_q] = 1'b1;
                    et_d           = 1'b1;
                    eid_d          = grant_q;
                    state_d        = WR_RELAY;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            RD_RELAY: begin
                if (!consumer_read_valid[grant_q]) begin
                    crr_d[grant_q] = 1'b0;
                    state_d        = IDLE;
                end
            end
            WR_RELAY: begin
                if (!consumer_write_valid[grant_q]) begin
                    cwr_d[grant_q] = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transaction without a ready pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            mrv_q    <= 1'b0;
            mwv_q    <= 1'b0;
            mra_q    <= '0;
            mwa_q    <= '0;
            mwd_q    <= '0;
            crr_q    <= '0;
            cwr_q    <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                crd_q[i] <= '0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            wd_q     <= '0;
            et_q     <= 1'b0;
            eid_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            mrv_q    <= mrv_d;
            mwv_q    <= mwv_d;
            mra_q    <= mra_d;
            mwa_q    <= mwa_d;
            mwd_q    <= mwd_d;
            crr_q    <= crr_d;
            cwr_q    <= cwr_d;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                crd_q[i] <= crd_d[i];
            end
`ifdef MEM_ARB_TIMEOUT_EN
            wd_q     <= wd_d;
            et_q     <= et_d;
            eid_q    <= eid_d;
`endif
        end
    end

    assign consumer_read_ready  = crr_q;
    assign consumer_read_data   = crd_q;
    assign consumer_write_ready = cwr_q;
    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign busy                 = (state_q != IDLE);
    assign grant_id             = grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign err_timeout          = et_q;
    assign err_id               = eid_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - directed bench with transaction-level reference model for mem_rr_arbiter
module tb_mem_rr_arbiter;

    localparam int A = 8;
    localparam int D = 16;
    localparam int N = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] c_rv, c_wv, c_rr, c_wr;
    logic [A-1:0] c_ra [N];
    logic [A-1:0] c_wa [N];
    logic [D-1:0] c_rd [N];
    logic [D-1:0] c_wd [N];
    logic mrv, mrr, mwv, mwr, busy;
    logic [A-1:0] mra, mwa;
    logic [D-1:0] mrd, mwd;
    logic [1:0] gid;
`ifdef MEM_ARB_TIMEOUT_EN
    logic err_t;
    logic [1:0] err_i;
    logic nw_err_t;
    logic [1:0] nw_err_i;
`endif

    // second instance with writes disabled, driven independently
    logic [N-1:0] nw_rv, nw_wv, nw_rr, nw_wr;
    logic [A-1:0] nw_ra [N];
    logic [A-1:0] nw_wa [N];
    logic [D-1:0] nw_rd [N];
    logic [D-1:0] nw_wd [N];
    logic nw_mrv, nw_mwv, nw_busy;
    logic [A-1:0] nw_mra, nw_mwa;
    logic [D-1:0] nw_mwd;
    logic [1:0] nw_gid;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N), .WRITE_ENABLE(1)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr),
        .busy(busy), .grant_id(gid)
`ifdef MEM_ARB_TIMEOUT_EN
        , .err_timeout(err_t), .err_id(err_i)
`endif
    );

    mem_rr_arbiter #(
        .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N), .WRITE_ENABLE(0)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut_nw (
        .clk(clk), .reset(reset),
        .consumer_read_valid(nw_rv), .consumer_read_address(nw_ra),
        .consumer_read_ready(nw_rr), .consumer_read_data(nw_rd),
        .consumer_write_valid(nw_wv), .consumer_write_address(nw_wa),
        .consumer_write_data(nw_wd), .consumer_write_ready(nw_wr),
        .mem_read_valid(nw_mrv), .mem_read_address(nw_mra),
        .mem_read_ready(1'b0), .mem_read_data(16'h0),
        .mem_write_valid(nw_mwv), .mem_write_address(nw_mwa),
        .mem_write_data(nw_mwd), .mem_write_ready(1'b0),
        .busy(nw_busy), .grant_id(nw_gid)
`ifdef MEM_ARB_TIMEOUT_EN
        , .err_timeout(nw_err_t), .err_id(nw_err_i)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the channel, in which phase, and what the outputs must read.
    int m_phase;        // 0 = free, 1 = memory access outstanding, 2 = waiting for requester release
    int m_owner;
    bit m_is_wr;
    int m_ptr;
    int m_gid;
    int m_wdog;
    logic m_rv, m_wv;
    logic [A-1:0] m_ra, m_wa;
    logic [D-1:0] m_wdat;
    logic [N-1:0] m_rrdy, m_wrdy;
    logic [D-1:0] m_rdata [N];
    bit m_err;
    int m_err_id;
    bit m_hit;
    bit m_done;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_owner = 0; m_is_wr = 0; m_ptr = 0; m_gid = 0; m_wdog = 0;
            m_rv = 0; m_wv = 0; m_ra = '0; m_wa = '0; m_wdat = '0;
            m_rrdy = '0; m_wrdy = '0; m_err = 0; m_err_id = 0;
            for (int i = 0; i < N; i++) m_rdata[i] = '0;
        end else if (m_phase == 0) begin
            m_hit = 0;
            for (int k = 0; k < N; k++) begin
                if (!m_hit && (c_rv[(m_ptr + k) % N] || c_wv[(m_ptr + k) % N])) begin
                    m_hit = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            if (m_hit) begin
                m_gid = m_owner;
                m_ptr = (m_owner + 1) % N;
                m_is_wr = !c_rv[m_owner];
                m_wdog = 0;
                m_phase = 1;
                if (m_is_wr) begin
                    m_wv = 1; m_wa = c_wa[m_owner]; m_wdat = c_wd[m_owner];
                end else begin
                    m_rv = 1; m_ra = c_ra[m_owner];
                end
            end
        end else if (m_phase == 1) begin
            m_done = m_is_wr ? mwr : mrr;
            if (m_done) begin
                m_phase = 2;
                if (m_is_wr) begin
                    m_wv = 0; m_wrdy[m_owner] = 1;
                end else begin
                    m_rv = 0; m_rrdy[m_owner] = 1; m_rdata[m_owner] = mrd;
                end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_wdog == TO - 1) begin
                m_phase = 2; m_err = 1; m_err_id = m_owner;
                if (m_is_wr) begin
                    m_wv = 0; m_wrdy[m_owner] = 1;
                end else begin
                    m_rv = 0; m_rrdy[m_owner] = 1; m_rdata[m_owner] = '0;
                end
            end else begin
                m_wdog++;
            end
`endif
        end else begin
            if (!(m_is_wr ? c_wv[m_owner] : c_rv[m_owner])) begin
                m_phase = 0;
                m_rrdy[m_owner] = 0;
                m_wrdy[m_owner] = 0;
            end
        end
    end

    // Compare every DUT output against the model each cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mem_read_valid", 32'(mrv), 32'(m_rv));
            chk("mem_read_address", 32'(mra), 32'(m_ra));
            chk("mem_write_valid", 32'(mwv), 32'(m_wv));
            chk("mem_write_address", 32'(mwa), 32'(m_wa));
            chk("mem_write_data", 32'(mwd), 32'(m_wdat));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("grant_id", 32'(gid), 32'(m_gid));
            chk("consumer_read_ready", 32'(c_rr), 32'(m_rrdy));
            chk("consumer_write_ready", 32'(c_wr), 32'(m_wrdy));
            for (int i = 0; i < N; i++) chk("consumer_read_data", 32'(c_rd[i]), 32'(m_rdata[i]));
`ifdef MEM_ARB_TIMEOUT_EN
            chk("err_timeout", 32'(err_t), 32'(m_err));
            chk("err_id", 32'(err_i), 32'(m_err_id));
`endif
        end
    end

    task automatic wait_mrv();
        for (int i = 0; i < 20 && !mrv; i++) tick();
        chk("wait_mem_read_valid", 32'(mrv), 1);
    endtask

    task automatic serve_read(input int c, input logic [D-1:0] data);
        wait_mrv();
        mrd = data; mrr = 1'b1;
        tick();
        mrr = 1'b0;
        chk("serve_read_ready", 32'(c_rr[c]), 1);
        c_rv[c] = 1'b0;
        tick();
    endtask

    int order [5];
    int n_wait;

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        c_rv = '0; c_wv = '0; mrr = 0; mwr = 0; mrd = '0;
        nw_rv = '0; nw_wv = '0;
        for (int i = 0; i < N; i++) begin
            c_ra[i] = '0; c_wa[i] = '0; c_wd[i] = '0;
            nw_ra[i] = '0; nw_wa[i] = '0; nw_wd[i] = '0;
        end
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_read_valid", 32'(mrv), 0);
        chk("rst_grant_id", 32'(gid), 0);
        reset = 1'b0;
        tick();

        // single read, consumer 2
        c_ra[2] = 8'h3C; c_rv[2] = 1'b1;
        tick();
        chk("t1_mem_read_valid", 32'(mrv), 1);
        chk("t1_mem_read_address", 32'(mra), 'h3C);
        chk("t1_grant_id", 32'(gid), 2);
        tick(); tick();
        mrd = 16'hBEEF; mrr = 1'b1;
        tick();
        mrr = 1'b0;
        chk("t1_consumer_read_ready", 32'(c_rr), 'h4);
        chk("t1_consumer_read_data", 32'(c_rd[2]), 'hBEEF);
        chk("t1_mem_read_valid_drop", 32'(mrv), 0);
        c_rv[2] = 1'b0;
        tick();
        chk("t1_ready_clear", 32'(c_rr), 0);
        chk("t1_idle", 32'(busy), 0);

        // fairness with every consumer requesting
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < N; i++) c_ra[i] = 8'(8'h40 + i);
        c_rv = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_mrv();
            order[n] = int'(gid);
            mrd = 16'(16'hA000 + n); mrr = 1'b1;
            tick();
            mrr = 1'b0;
            chk("t2_data", 32'(c_rd[order[n]]), 32'(16'hA000 + n));
            c_rv[order[n]] = 1'b0;
            tick();
            c_rv[order[n]] = 1'b1;
        end
        c_rv = '0;
        chk("t2_order0", order[0], 0);
        chk("t2_order1", order[1], 1);
        chk("t2_order2", order[2], 2);
        chk("t2_order3", order[3], 3);
        chk("t2_order4", order[4], 0);
        tick();

        // consumer 1 read and write together: read first
        c_ra[1] = 8'h20; c_wa[1] = 8'h10; c_wd[1] = 16'h1234;
        c_rv[1] = 1'b1; c_wv[1] = 1'b1;
        tick();
        chk("t3_read_first", 32'(mrv), 1);
        chk("t3_no_write_yet", 32'(mwv), 0);
        chk("t3_grant_id", 32'(gid), 1);
        mrd = 16'h5A5A; mrr = 1'b1;
        tick();
        mrr = 1'b0;
        chk("t3_read_ready", 32'(c_rr), 'h2);
        c_rv[1] = 1'b0;
        tick(); tick();
        chk("t3_mem_write_valid", 32'(mwv), 1);
        chk("t3_mem_write_address", 32'(mwa), 'h10);
        chk("t3_mem_write_data", 32'(mwd), 'h1234);
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        chk("t3_write_ready", 32'(c_wr), 'h2);
        c_wv[1] = 1'b0;
        tick();
        chk("t3_write_ready_clear", 32'(c_wr), 0);

        // writes disabled: a write-only request is never granted
        nw_wa[0] = 8'h33; nw_wd[0] = 16'h7777; nw_wv[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_no_mem_write_valid", 32'(nw_mwv), 0);
            chk("t4_busy_low", 32'(nw_busy), 0);
            chk("t4_no_write_ready", 32'(nw_wr), 0);
        end
        nw_wv[0] = 1'b0;

        // reset in the middle of a read wait
        c_ra[0] = 8'h55; c_rv[0] = 1'b1;
        tick();
        chk("t5_granted", 32'(mrv), 1);
        tick();
        reset = 1'b1;
        tick();
        chk("t5_rst_mem_read_valid", 32'(mrv), 0);
        chk("t5_rst_mem_read_address", 32'(mra), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ready", 32'(c_rr), 0);
        chk("t5_rst_data1", 32'(c_rd[1]), 0);
        reset = 1'b0;
        c_ra[1] = 8'h66; c_rv[1] = 1'b1;
        tick();
        chk("t5_ptr_zero_grant", 32'(gid), 0);
        chk("t5_addr", 32'(mra), 'h55);
        serve_read(0, 16'h1111);
        serve_read(1, 16'h2222);
        chk("t5_data1", 32'(c_rd[1]), 'h2222);

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers: watchdog releases consumer 3
        c_ra[3] = 8'h70; c_rv[3] = 1'b1;
        serve_read(3, 16'hCAFE);
        chk("t6_pre_data", 32'(c_rd[3]), 'hCAFE);
        c_ra[3] = 8'h77; c_rv[3] = 1'b1;
        wait_mrv();
        n_wait = 0;
        for (int i = 0; i < 40 && mrv; i++) begin
            n_wait++;
            tick();
        end
        chk("t6_wait_cycles", n_wait, 8);
        chk("t6_ready", 32'(c_rr), 'h8);
        chk("t6_data_zero", 32'(c_rd[3]), 0);
        chk("t6_err_timeout", 32'(err_t), 1);
        chk("t6_err_id", 32'(err_i), 3);
        c_rv[3] = 1'b0;
        tick();
        chk("t6_idle", 32'(busy), 0);
        chk("t6_err_sticky", 32'(err_t), 1);
`endif

        tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Shares one memory channel between NUM_CONSUMERS load/store requesters using round-robin fairness. Sits between the per-core LSUs and a single memory channel. Uses the codebase valid/ready handshake on both sides: requester holds valid until ready; ready is held until valid drops. Adds grant visibility and an optional watchdog for stuck memory responses.

Parameters:
ADDR_BITS, 8, address width
DATA_BITS, 16, data width
NUM_CONSUMERS, 4, requester count (>=2)
WRITE_ENABLE, 1, 0 ties all write paths off (write requests never granted)
TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock; the block uses one clock
reset  in  1  synchronous, active-high reset
consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS (unpacked)  read address
consumer_read_ready  out  NUM_CONSUMERS  read complete; data valid
consumer_read_data  out  DATA_BITS x NUM_CONSUMERS (unpacked)  read data
consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
consumer_write_ready  out  NUM_CONSUMERS  write complete
mem_read_valid  out  1  read request to memory
mem_read_address  out  ADDR_BITS  read address
mem_read_ready  in  1  memory read done
mem_read_data  in  DATA_BITS  memory read data
mem_write_valid  out  1  write request to memory
mem_write_address  out  ADDR_BITS  write address
mem_write_data  out  DATA_BITS  write data
mem_write_ready  in  1  memory write done
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_CONSUMERS)  consumer currently owning the channel

Behaviour:
- Reset: every output register is 0, including all consumer_read_data entries. rr_ptr=0, state=IDLE. Reset mid-transaction aborts the transaction silently; no ready pulse is produced.
- States are IDLE, RD_WAIT, WR_WAIT, RD_RELAY, WR_RELAY.
- IDLE arbitration:
  - Scan j = rr_ptr, rr_ptr+1, ... mod NUM_CONSUMERS.
  - The first j with read_valid or write_valid (write only if WRITE_ENABLE) wins.
  - If the winner has both read and write valid, the read goes first.
  - On grant: latch address (and data for writes), set grant_id=j, and set mem_*_valid=1 (visible the cycle after the grant).
  - Next state is RD_WAIT or WR_WAIT; rr_ptr <= (j+1) mod NUM_CONSUMERS, wrapping at NUM_CONSUMERS-1 -> 0.
  - With no request, stay in IDLE and leave rr_ptr unchanged.
- RD_WAIT / WR_WAIT:
  - Hold valid, address and data stable until the matching mem ready is sampled high.
  - On ready: drop mem valid and set consumer_*_ready[grant_id]=1.
  - For reads, also register consumer_read_data[grant_id]=mem_read_data.
  - Next state is RD_RELAY / WR_RELAY.
  - The opposite-type ready input is ignored.
- RD_RELAY / WR_RELAY:
  - When consumer_*_valid[grant_id] drops, clear that ready and return to IDLE.
  - consumer_read_data keeps its last value.
  - Other consumers' requests stay pending throughout; they are never dropped.
- Latency: a request seen in IDLE at cycle 0 drives mem valid at cycle 1. Memory ready at cycle k gives consumer ready at k+1. A new grant is possible the cycle after the RELAY exit.
- Fairness: with all consumers requesting continuously, grants rotate 0,1,2,3,0,...

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - Adds a counter in RD_WAIT/WR_WAIT, cleared on entry.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready: drop mem valid and pulse consumer ready to release the requester. Read data is forced to 0.
  - Sets sticky output err_timeout (1 bit) and err_id (grant_id width). Both clear only on reset.
  - Next state is RELAY.
- Undefined: no counter and no err ports; WAIT states last indefinitely.

Decomposition:
- Package mem_arb_pkg holds the state enum (3-bit) and a helper function rr_next(ptr, N) for modulo increment.
- One natural sub-module, rr_priority_pick: combinational rotate/priority-find returning winner index and found flag. It is reusable for the future dispatcher.

Test Plan:
- Single read, consumer 2, addr 0x3C; memory returns 0xBEEF two cycles after valid -> mem_read_address=0x3C; consumer_read_ready[2] high one cycle after mem ready; data 0xBEEF; grant_id=2.
- All four consumers assert read valid permanently -> grant order 0,1,2,3,0; no consumer is granted twice before the others.
- Consumer 1 asserts read and write together (write addr 0x10, data 0x1234) -> read serviced first; write issued after consumer 1 drops read valid; mem_write_data=0x1234.
- WRITE_ENABLE=0, consumer 0 write valid only -> no mem_write_valid ever; busy stays 0.
- Reset asserted in RD_WAIT -> next cycle all outputs 0, state IDLE, rr_ptr 0, no consumer ready.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, memory never ready, consumer 3 reads -> after 8 wait cycles consumer_read_ready[3]=1, data 0, err_timeout=1, err_id=3.
